// File: rtl/div32_seq.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned.
// start is taken only in IDLE; results appear with a one-cycle done pulse and then hold.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_acc, rem_acc, dvs_q;
    logic             neg_q, neg_r, zero_pend;

    logic             accept, b_zero;
    logic [WIDTH-1:0] mag_a, mag_b, q_next, r_next;
    logic [WIDTH:0]   shifted, trial;
    logic             q_bit;

    always_comb begin
        b_zero  = (srcb == '0);
        mag_a   = (is_signed && srca[WIDTH-1]) ? -srca : srca;
        mag_b   = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;
        accept  = (state_q == IDLE) && !zero_pend && start;
        // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial exactly.
        shifted = {rem_acc, quo_acc[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        q_bit   = ~trial[WIDTH];
        r_next  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_next  = {quo_acc[WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (zero_pend)
                    state_d = DONE;
                else if (accept && !b_zero)
                    state_d = CALC;
            end
            CALC: begin
                if (cnt_q == '0)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            quo_acc     <= '0;
            rem_acc     <= '0;
            dvs_q       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_pend   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            neg_q     <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_r     <= is_signed & srca[WIDTH-1];
            dvs_q     <= mag_b;
            rem_acc   <= '0;
            // A zero divisor keeps the raw dividend, which becomes the remainder.
            quo_acc   <= b_zero ? srca : mag_a;
            zero_pend <= b_zero;
            cnt_q     <= CW'(WIDTH - 1);
        end else if (zero_pend) begin
            zero_pend   <= 1'b0;
            quotient    <= '1;
            remainder   <= quo_acc;
            div_by_zero <= 1'b1;
        end else if (state_q == CALC) begin
            quo_acc <= q_next;
            rem_acc <= r_next;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end else begin
                quotient    <= neg_q ? -q_next : q_next;
                remainder   <= neg_r ? -r_next : r_next;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: vector table, random cases against a reference model,
// and hand-written sequences for reset, ignored starts and latency.
module tb_div32_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] srca, srcb;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    logic [1:0]   dbg_state;

    div32_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .srca        (srca),
        .srcb        (srcb),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // scoreboard: {div_by_zero, quotient, remainder}
    logic [2*W:0] exp_q[$];
    logic [2*W:0] last_exp;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0)
            return {1'b1, {W{1'b1}}, a};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {1'b0, 32'h8000_0000, 32'h0};
            return {1'b0, 32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
        end
        return {1'b0, a / b, a % b};
    endfunction

    // driver: present a request for one edge, then scramble the operand pins
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W:0] e, input bit push);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        srca      = a;
        srcb      = b;
        if (push) begin
            exp_q.push_back(e);
            last_exp = e;
        end
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        srca      = $urandom;
        srcb      = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    // called on the negedge right after the accept edge; returns on the done cycle
    task automatic collect(input string name, input int exp_lat, input int exp_busy);
        int lat = 0;
        int bcnt = 0;
        logic [2*W:0] e;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy_cycles"}, 64'(bcnt), 64'(exp_busy));
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, " quotient"}, 64'(quotient), 64'(e[2*W-1:W]));
            check({name, " remainder"}, 64'(remainder), 64'(e[W-1:0]));
            check({name, " div_by_zero"}, 64'(div_by_zero), 64'(e[2*W]));
        end
    endtask

    task automatic post_done(input string name);
        @(negedge clk);
        check({name, " done_pulse"}, 64'(done), 64'd0);
        check({name, " idle_state"}, 64'(dbg_state), 64'd0);
        check({name, " hold_q"}, 64'(quotient), 64'(last_exp[2*W-1:W]));
        check({name, " hold_r"}, 64'(remainder), 64'(last_exp[W-1:0]));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
        vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vecs[10] = '{1'b0, 32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};
        vecs[11] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
        vecs[12] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};

        // reset with a request already waiting on the pins
        rst_n     = 1'b0;
        start     = 1'b1;
        is_signed = 1'b0;
        srca      = 32'd100;
        srcb      = 32'd7;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset quotient", 64'(quotient), 64'd0);
        check("reset remainder", 64'(remainder), 64'd0);
        check("reset div_by_zero", 64'(div_by_zero), 64'd0);
        check("reset state", 64'(dbg_state), 64'd0);

        // the first edge with rst_n high must accept
        last_exp = {1'b0, 32'd14, 32'd2};
        exp_q.push_back(last_exp);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        srca  = $urandom;
        srcb  = $urandom;
        collect("first_after_reset", 32, 32);
        post_done("first_after_reset");

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].s, vecs[i].a, vecs[i].b, {vecs[i].dz, vecs[i].q, vecs[i].r}, 1'b1);
            collect($sformatf("vec%0d", i), (vecs[i].b == '0) ? 1 : 32, (vecs[i].b == '0) ? 0 : 32);
            post_done($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            logic         s;
            logic [W-1:0] a, b;
            s = 1'(i % 2);
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            issue(s, a, b, model(s, a, b), 1'b1);
            collect($sformatf("rnd%0d", i), 32, 32);
            post_done($sformatf("rnd%0d", i));
        end

        // start pulsed while busy must not disturb the running division
        issue(1'b0, 32'd100, 32'd7, {1'b0, 32'd14, 32'd2}, 1'b1);
        start     = 1'b1;
        is_signed = 1'b1;
        srca      = 32'd1000;
        srcb      = 32'd3;
        @(negedge clk);
        start = 1'b0;
        collect("start_in_calc", 31, 31);
        post_done("start_in_calc");
        repeat (3) @(negedge clk);
        check("start_in_calc not_executed", 64'(busy), 64'd0);

        // start raised in the done cycle is dropped
        issue(1'b0, 32'd100, 32'd7, {1'b0, 32'd14, 32'd2}, 1'b1);
        collect("start_in_done", 32, 32);
        start = 1'b1;
        srca  = 32'd5;
        srcb  = 32'd0;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        check("start_in_done no_result", 64'(done), 64'd0);
        check("start_in_done dz_clear", 64'(div_by_zero), 64'd0);
        check("start_in_done hold_q", 64'(quotient), 64'd14);

        // asynchronous reset after the tenth iteration of 1000/3
        issue(1'b0, 32'd1000, 32'd3, '0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset quotient", 64'(quotient), 64'd0);
        check("midreset remainder", 64'(remainder), 64'd0);
        check("midreset div_by_zero", 64'(div_by_zero), 64'd0);
        check("midreset state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset discarded", 64'(busy), 64'd0);
        issue(1'b0, 32'd1000, 32'd3, {1'b0, 32'd333, 32'd1}, 1'b1);
        collect("after_midreset", 32, 32);
        post_done("after_midreset");

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
